// File: rtl/ipif_pkg.sv
// Shared types and index helpers for the IPIF broadcast router.
// IPIF vectors are big-endian (MSB = chip 0); the downstream side is little-endian.
package ipif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StDrain
  } ipif_state_e;

  // Like $clog2, but never returns 0, so a width built from it is always at least 1.
  function automatic int unsigned clog2s(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Bit position of chip `chip` inside a big-endian chip-select vector.
  function automatic int unsigned cs_be_idx(input int unsigned chip, input int unsigned n_chip);
    return n_chip - 1 - chip;
  endfunction

  // Bit position of register `r_idx` of chip `chip` inside a big-endian CE vector.
  function automatic int unsigned ce_be_idx(input int unsigned chip, input int unsigned r_idx,
                                            input int unsigned n_chip, input int unsigned n_reg);
    return n_chip * n_reg - 1 - (chip * n_reg + r_idx);
  endfunction

endpackage

// File: rtl/ipif_ack_collector.sv
// Tracks which chips still owe an ack for the current transaction, ORs their errors,
// captures read data and forces completion when the wait exceeds the timeout.
module ipif_ack_collector
  import ipif_pkg::*;
#(
  parameter int unsigned       NChip       = 4,
  parameter int unsigned       DataW       = 32,
  parameter int unsigned       TimeoutCyc  = 256,
  parameter logic [DataW-1:0]  TimeoutData = 32'hDEADBEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [NChip-1:0]       start_mask_i,
  input  logic                   active_i,
  input  logic                   rnw_i,
  input  logic [NChip-1:0]       wr_ack_i,
  input  logic [NChip-1:0]       rd_ack_i,
  input  logic [NChip-1:0]       err_i,
  input  logic [NChip*DataW-1:0] data_i,
  output logic [NChip-1:0]       pending_o,
  output logic                   err_o,
  output logic [DataW-1:0]       rdata_o
);

  localparam int unsigned TimerW = clog2s(TimeoutCyc + 1);

  logic [NChip-1:0]  pending_q, pending_d;
  logic              err_q, err_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic [TimerW-1:0] timer_q, timer_d;

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;
    if (start_i) begin
      pending_d = start_mask_i;
      err_d     = 1'b0;
      rdata_d   = '0;
      timer_d   = '0;
    end else if (active_i) begin
      for (int i = 0; i < NChip; i++) begin
        // Only the ack type matching the request counts; stray acks are ignored.
        if (pending_q[i] && (rnw_i ? rd_ack_i[i] : wr_ack_i[i])) begin
          pending_d[i] = 1'b0;
          err_d        = err_d | err_i[i];
          if (rnw_i) begin
            rdata_d = data_i[i*DataW +: DataW];
          end
        end
      end
      if ((TimeoutCyc != 0) && (pending_d != '0) && (timer_q == TimerW'(TimeoutCyc - 1))) begin
        pending_d = '0;
        err_d     = 1'b1;
        rdata_d   = TimeoutData;
      end
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timer_q   <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state view so the top can register the downstream CS/CE and the response together.
  assign pending_o = pending_d;
  assign err_o     = err_d;
  assign rdata_o   = rdata_d;

endmodule

// File: rtl/ipif_broadcast_router.sv
// Registered 1-to-N IPIF router: one transaction at a time to one chip, or a write
// broadcast to all chips for registers flagged in BROADCAST_REG.
module ipif_broadcast_router
  import ipif_pkg::*;
#(
  parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   N_CHIP             = 4,
  parameter int unsigned                   N_REG              = 8,
  parameter logic [N_REG-1:0]              BROADCAST_REG      = '0,
  parameter int unsigned                   TIMEOUT_CYC        = 256,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] TIMEOUT_DATA       = 32'hDEADBEEF
) (
  input  logic                                   Bus2IP_Clk,
  input  logic                                   Bus2IP_Resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_Bus2IP_Addr,
  input  logic                                   s_Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_Bus2IP_BE,
  input  logic [N_CHIP-1:0]                      s_Bus2IP_CS,
  input  logic [N_CHIP*N_REG-1:0]                s_Bus2IP_RdCE,
  input  logic [N_CHIP*N_REG-1:0]                s_Bus2IP_WrCE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s_IP2Bus_Data,
  output logic                                   s_IP2Bus_WrAck,
  output logic                                   s_IP2Bus_RdAck,
  output logic                                   s_IP2Bus_Error,
  output logic [N_CHIP*C_S_AXI_ADDR_WIDTH-1:0]   m_Bus2IP_Addr,
  output logic [N_CHIP-1:0]                      m_Bus2IP_RNW,
  output logic [N_CHIP*C_S_AXI_DATA_WIDTH/8-1:0] m_Bus2IP_BE,
  output logic [N_CHIP*C_S_AXI_DATA_WIDTH-1:0]   m_Bus2IP_Data,
  output logic [N_CHIP-1:0]                      m_Bus2IP_CS,
  output logic [N_CHIP*N_REG-1:0]                m_Bus2IP_RdCE,
  output logic [N_CHIP*N_REG-1:0]                m_Bus2IP_WrCE,
  input  logic [N_CHIP*C_S_AXI_DATA_WIDTH-1:0]   m_IP2Bus_Data,
  input  logic [N_CHIP-1:0]                      m_IP2Bus_WrAck,
  input  logic [N_CHIP-1:0]                      m_IP2Bus_RdAck,
  input  logic [N_CHIP-1:0]                      m_IP2Bus_Error
);

  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned BW       = DW / 8;
  localparam int unsigned NCe      = N_CHIP * N_REG;
  localparam int unsigned AddrKeep = clog2s(N_REG) + 2;
  localparam logic [AW-1:0] AddrMask = {{(AW - AddrKeep){1'b0}}, {AddrKeep{1'b1}}};

  ipif_state_e       state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rnw_q, rnw_d;
  logic [BW-1:0]     be_q, be_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [N_REG-1:0]  reg_sel_q, reg_sel_d;
  logic [N_CHIP-1:0] m_cs_q, m_cs_d;
  logic [NCe-1:0]    m_rdce_q, m_rdce_d, m_wrce_q, m_wrce_d;
  logic              s_rdack_q, s_rdack_d, s_wrack_q, s_wrack_d, s_err_q, s_err_d;
  logic [DW-1:0]     s_data_q, s_data_d;

  logic [N_CHIP-1:0] cs_le, start_mask, col_pending;
  logic [N_REG-1:0]  ce_slice;
  logic              dec_valid, dec_bcast, start, active, col_err;
  logic [DW-1:0]     col_rdata;
  logic [NCe-1:0]    ce_all;

  // Decode of the incoming request; only meaningful while idle.
  always_comb begin
    cs_le    = '0;
    ce_slice = '0;
    for (int i = 0; i < N_CHIP; i++) begin
      cs_le[i] = s_Bus2IP_CS[cs_be_idx(i, N_CHIP)];
      for (int r = 0; r < N_REG; r++) begin
        // OR across chips gated by CS equals the selected chip's slice when CS is one-hot.
        ce_slice[r] = ce_slice[r] | (cs_le[i] &
                      (s_Bus2IP_RNW ? s_Bus2IP_RdCE[ce_be_idx(i, r, N_CHIP, N_REG)]
                                    : s_Bus2IP_WrCE[ce_be_idx(i, r, N_CHIP, N_REG)]));
      end
    end
    dec_valid  = $onehot(cs_le) && $onehot(ce_slice);
    dec_bcast  = !s_Bus2IP_RNW && cs_le[0] && ((ce_slice & BROADCAST_REG) != '0);
    start_mask = dec_bcast ? '1 : cs_le;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    reg_sel_d = reg_sel_q;
    s_rdack_d = 1'b0;
    s_wrack_d = 1'b0;
    s_err_d   = 1'b0;
    s_data_d  = '0;
    start     = 1'b0;
    active    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_Bus2IP_CS != '0) begin
          addr_d    = s_Bus2IP_Addr;
          rnw_d     = s_Bus2IP_RNW;
          be_d      = s_Bus2IP_BE;
          wdata_d   = s_Bus2IP_Data;
          reg_sel_d = ce_slice;
          if (dec_valid) begin
            start   = 1'b1;
            state_d = StWait;
          end else begin
            state_d   = StResp;
            s_rdack_d = s_Bus2IP_RNW;
            s_wrack_d = !s_Bus2IP_RNW;
            s_err_d   = 1'b1;
            s_data_d  = s_Bus2IP_RNW ? TIMEOUT_DATA : '0;
          end
        end
      end
      StWait: begin
        active = 1'b1;
        if (col_pending == '0) begin
          state_d   = StResp;
          s_rdack_d = rnw_q;
          s_wrack_d = !rnw_q;
          s_err_d   = col_err;
          s_data_d  = rnw_q ? col_rdata : '0;
        end
      end
      StResp: state_d = StDrain;
      StDrain: begin
        // Hold here until the master releases CS so a held CS cannot start a second transfer.
        if (s_Bus2IP_CS == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_cs_d = col_pending;
    ce_all = '0;
    for (int i = 0; i < N_CHIP; i++) begin
      for (int r = 0; r < N_REG; r++) begin
        ce_all[i*N_REG+r] = col_pending[i] & reg_sel_d[r];
      end
    end
    m_rdce_d = rnw_d ? ce_all : '0;
    m_wrce_d = rnw_d ? '0 : ce_all;
  end

  ipif_ack_collector #(
    .NChip      (N_CHIP),
    .DataW      (DW),
    .TimeoutCyc (TIMEOUT_CYC),
    .TimeoutData(TIMEOUT_DATA)
  ) u_ack_collector (
    .clk_i       (Bus2IP_Clk),
    .rst_ni      (Bus2IP_Resetn),
    .start_i     (start),
    .start_mask_i(start_mask),
    .active_i    (active),
    .rnw_i       (rnw_q),
    .wr_ack_i    (m_IP2Bus_WrAck),
    .rd_ack_i    (m_IP2Bus_RdAck),
    .err_i       (m_IP2Bus_Error),
    .data_i      (m_IP2Bus_Data),
    .pending_o   (col_pending),
    .err_o       (col_err),
    .rdata_o     (col_rdata)
  );

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rnw_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      reg_sel_q <= '0;
      m_cs_q    <= '0;
      m_rdce_q  <= '0;
      m_wrce_q  <= '0;
      s_rdack_q <= 1'b0;
      s_wrack_q <= 1'b0;
      s_err_q   <= 1'b0;
      s_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rnw_q     <= rnw_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      reg_sel_q <= reg_sel_d;
      m_cs_q    <= m_cs_d;
      m_rdce_q  <= m_rdce_d;
      m_wrce_q  <= m_wrce_d;
      s_rdack_q <= s_rdack_d;
      s_wrack_q <= s_wrack_d;
      s_err_q   <= s_err_d;
      s_data_q  <= s_data_d;
    end
  end

  assign s_IP2Bus_Data  = s_data_q;
  assign s_IP2Bus_RdAck = s_rdack_q;
  assign s_IP2Bus_WrAck = s_wrack_q;
  assign s_IP2Bus_Error = s_err_q;
  assign m_Bus2IP_Addr  = {N_CHIP{addr_q & AddrMask}};
  assign m_Bus2IP_RNW   = {N_CHIP{rnw_q}};
  assign m_Bus2IP_BE    = {N_CHIP{be_q}};
  assign m_Bus2IP_Data  = {N_CHIP{wdata_q}};
  assign m_Bus2IP_CS    = m_cs_q;
  assign m_Bus2IP_RdCE  = m_rdce_q;
  assign m_Bus2IP_WrCE  = m_wrce_q;

endmodule

// File: tb/tb_ipif_broadcast_router.sv
// Scoreboard bench: directed transactions push expected responses, a monitor checks acks.
module tb_ipif_broadcast_router;

  localparam int unsigned NC = 4;
  localparam int unsigned NR = 8;
  localparam logic [NR-1:0] BREG = 8'b0010_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      s_addr = '0;
  logic             s_rnw = 1'b0;
  logic [3:0]       s_be = '0;
  logic [NC-1:0]    s_cs = '0;
  logic [NC*NR-1:0] s_rdce = '0, s_wrce = '0;
  logic [31:0]      s_wdata = '0;
  logic [31:0]      s_rdata;
  logic             s_wrack, s_rdack, s_err;
  logic [NC*32-1:0] m_addr, m_wdata;
  logic [NC-1:0]    m_rnw, m_cs;
  logic [NC*4-1:0]  m_be;
  logic [NC*NR-1:0] m_rdce, m_wrce;
  logic [NC*32-1:0] m_rdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  logic [NC-1:0]    m_wrack = '0, m_rdack = '0, m_err = '0;

  ipif_broadcast_router #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .N_CHIP            (NC),
    .N_REG             (NR),
    .BROADCAST_REG     (BREG),
    .TIMEOUT_CYC       (16),
    .TIMEOUT_DATA      (32'hDEADBEEF)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .s_Bus2IP_Addr (s_addr),
    .s_Bus2IP_RNW  (s_rnw),
    .s_Bus2IP_BE   (s_be),
    .s_Bus2IP_CS   (s_cs),
    .s_Bus2IP_RdCE (s_rdce),
    .s_Bus2IP_WrCE (s_wrce),
    .s_Bus2IP_Data (s_wdata),
    .s_IP2Bus_Data (s_rdata),
    .s_IP2Bus_WrAck(s_wrack),
    .s_IP2Bus_RdAck(s_rdack),
    .s_IP2Bus_Error(s_err),
    .m_Bus2IP_Addr (m_addr),
    .m_Bus2IP_RNW  (m_rnw),
    .m_Bus2IP_BE   (m_be),
    .m_Bus2IP_Data (m_wdata),
    .m_Bus2IP_CS   (m_cs),
    .m_Bus2IP_RdCE (m_rdce),
    .m_Bus2IP_WrCE (m_wrce),
    .m_IP2Bus_Data (m_rdata),
    .m_IP2Bus_WrAck(m_wrack),
    .m_IP2Bus_RdAck(m_rdack),
    .m_IP2Bus_Error(m_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t          sb[$];
  int unsigned   cyc = 0;
  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;
  int unsigned   dly[NC];
  logic          serr[NC];
  int unsigned   cnt[NC];
  logic [NC-1:0] wrote = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NC*NR-1:0] be_ce(input int chip, input int r);
    logic [NC*NR-1:0] v;
    v = '0;
    v[NC*NR-1-(chip*NR+r)] = 1'b1;
    return v;
  endfunction

  // Slave model: chip i acks in the dly[i]-th cycle its CS is high (255 = never).
  initial begin
    for (int i = 0; i < NC; i++) begin
      dly[i] = 1; serr[i] = 1'b0; cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
        m_wrack[i] = 1'b0; m_rdack[i] = 1'b0; m_err[i] = 1'b0;
        if (m_cs[i]) begin
          cnt[i]++;
          if (m_wrce[i*NR +: NR] != '0) wrote[i] = 1'b1;
          if (cnt[i] == dly[i]) begin
            if (m_rnw[i]) m_rdack[i] = 1'b1;
            else m_wrack[i] = 1'b1;
            m_err[i] = serr[i];
          end
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  // Monitor: every upstream ack must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && (s_rdack || s_wrack)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: rdack=%b wrack=%b at cycle %0d", s_rdack, s_wrack, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_kind", {30'd0, s_rdack, s_wrack}, {30'd0, e.rnw, !e.rnw});
        check("ack_error", {31'd0, s_err}, {31'd0, e.err});
        check("ack_data", s_rdata, e.data);
        check("ack_latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [NC-1:0] cs, input logic rnw, input logic [NC*NR-1:0] rdce,
                       input logic [NC*NR-1:0] wrce, input logic [31:0] addr,
                       input logic [31:0] data, input logic push, input logic eerr,
                       input logic [31:0] edata, input int unsigned lat);
    @(posedge clk);
    #1;
    s_cs = cs; s_rnw = rnw; s_rdce = rdce; s_wrce = wrce; s_addr = addr;
    s_wdata = data; s_be = 4'hF;
    if (push) sb.push_back('{rnw, eerr, edata, cyc + lat});
  endtask

  task automatic finish_txn(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (s_rdack || s_wrack) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no ack within 200 cycles", name);
    end
    @(posedge clk);
    #1;
    s_cs = '0; s_rdce = '0; s_wrce = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic to_cycle1();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #3;
    check("reset_m_cs", {28'd0, m_cs}, 32'd0);
    check("reset_acks", {29'd0, s_rdack, s_wrack, s_err}, 32'd0);
    check("reset_rdata", s_rdata, 32'd0);
    check("reset_m_ce", m_rdce | m_wrce, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Read chip 2 reg 3; chip acks in its 2nd CS cycle.
    dly[2] = 2;
    issue(4'b0010, 1'b1, be_ce(2, 3), '0, 32'hABCD_0F2C, 32'h0, 1'b1, 1'b0, 32'h33333333, 3);
    to_cycle1();
    check("rd_m_cs", {28'd0, m_cs}, 32'h4);
    check("rd_m_rdce", m_rdce, 32'h0008_0000);
    check("rd_m_wrce", m_wrce, 32'h0);
    check("rd_m_addr", m_addr[2*32 +: 32], 32'h0000_000C);
    finish_txn("rd_chip2");

    // Broadcast write of reg 5; chips ack at cycles 1/3/5/2.
    dly[0] = 1; dly[1] = 3; dly[2] = 5; dly[3] = 2;
    issue(4'b1000, 1'b0, '0, be_ce(0, 5), 32'h14, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 6);
    to_cycle1();
    check("bc_m_cs", {28'd0, m_cs}, 32'hF);
    check("bc_m_wrce", m_wrce, 32'h2020_2020);
    check("bc_m_data3", m_wdata[3*32 +: 32], 32'hCAFE_F00D);
    @(negedge clk);
    check("bc_m_cs_cyc2", {28'd0, m_cs}, 32'hE);
    finish_txn("bc_write");

    // Broadcast write with chip 1 returning an error.
    for (int i = 0; i < NC; i++) dly[i] = 2;
    serr[1] = 1'b1;
    wrote = '0;
    issue(4'b1000, 1'b0, '0, be_ce(0, 5), 32'h14, 32'h1234_5678, 1'b1, 1'b1, 32'h0, 3);
    finish_txn("bc_err");
    serr[1] = 1'b0;
    check("bc_err_all_written", {28'd0, wrote}, 32'hF);

    // Non-broadcast write of reg 5 on chip 2 stays on chip 2.
    dly[2] = 3;
    issue(4'b0010, 1'b0, '0, be_ce(2, 5), 32'h14, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0, 4);
    to_cycle1();
    check("wr2_m_cs", {28'd0, m_cs}, 32'h4);
    check("wr2_m_wrce", m_wrce, 32'h0020_0000);
    finish_txn("wr_chip2");

    // Chip 3 never acks: timeout after 16 wait cycles.
    dly[3] = 255;
    issue(4'b0001, 1'b1, be_ce(3, 0), '0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 17);
    to_cycle1();
    check("to_m_cs", {28'd0, m_cs}, 32'h8);
    finish_txn("timeout");
    check("to_cs_dropped", {28'd0, m_cs}, 32'h0);

    // Two-hot CS: immediate error, nothing downstream.
    issue(4'b0110, 1'b1, be_ce(1, 0) | be_ce(2, 0), '0, 32'h0, 32'h0, 1'b1, 1'b1,
          32'hDEADBEEF, 1);
    @(negedge clk);
    check("twohot_m_cs", {28'd0, m_cs}, 32'h0);
    finish_txn("twohot");

    // One-hot CS but two WrCE bits: write decode error.
    issue(4'b0100, 1'b0, '0, be_ce(1, 2) | be_ce(1, 3), 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    @(negedge clk);
    check("twoce_m_cs", {28'd0, m_cs}, 32'h0);
    finish_txn("twoce");

    // Reset during WAIT aborts silently.
    dly[2] = 255;
    issue(4'b0010, 1'b1, be_ce(2, 1), '0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    to_cycle1();
    @(negedge clk);
    check("rst_pre_m_cs", {28'd0, m_cs}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_cs", {28'd0, m_cs}, 32'h0);
    check("rst_m_rdce", m_rdce, 32'h0);
    check("rst_acks", {29'd0, s_rdack, s_wrack, s_err}, 32'd0);
    s_cs = '0; s_rdce = '0; s_wrce = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    dly[2] = 2;
    issue(4'b0010, 1'b1, be_ce(2, 3), '0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h33333333, 3);
    finish_txn("after_reset");

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
